// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing one config port.
//
// Each channel counts enabled clk_0 cycles modulo its divisor and produces a
// one-cycle tick per period plus a registered square wave (clk_out). Neither
// output is a clock: both are meant to be used as enables or as sampled data.
//
// Ports:
//   clk_0      sole clock, rising edge
//   rst        asynchronous active-high reset
//   en         per-channel count enable
//   sync_all   restart every channel counter in phase (div/mode untouched)
//   cfg_valid  config write request
//   cfg_ready  config write can be accepted (low for one cycle after a write)
//   cfg_ch     target channel of the write
//   cfg_div    new divisor (0 = stopped, 1 = tick every cycle)
//   cfg_mode   0 = free-running, 1 = one-shot
//   cfg_err    one-cycle pulse: accepted write addressed a missing channel
//   tick       one-cycle pulse per divided period
//   clk_out    divided square wave, low floor(div/2), high ceil(div/2) cycles
module clock_divider_bank #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned CNT_W       = 28,
   parameter int unsigned CH_W        = 2,
   parameter int unsigned DEFAULT_DIV = 5
) (
   input  logic              clk_0,
   input  logic              rst,
   input  logic [N_CH-1:0]   en,
   input  logic              sync_all,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   output logic              cfg_err,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   clk_out
);

   localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
   // Channel count extended by one bit so N_CH == 2^CH_W still compares correctly.
   localparam logic [CH_W:0]    NChExt = (CH_W+1)'(N_CH);

   logic [CNT_W-1:0] div_q [N_CH];
   logic [CNT_W-1:0] div_d [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]  mode_q, mode_d;
   logic [N_CH-1:0]  halted_q, halted_d;
   logic [N_CH-1:0]  tick_q, tick_d;
   logic [N_CH-1:0]  clk_out_q, clk_out_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             cfg_err_q, cfg_err_d;

   logic             wr_acc;
   logic [N_CH-1:0]  wr_hit;
   logic [N_CH-1:0]  div_ge1;
   logic [N_CH-1:0]  div_ge2;
   logic [N_CH-1:0]  at_last;

   assign wr_acc = cfg_valid & cfg_ready_q;

   // Per-channel decode of the write target and of the counter position.
   always_comb begin
      for (int c = 0; c < int'(N_CH); c++) begin
         wr_hit[c]  = wr_acc & ({1'b0, cfg_ch} == (CH_W+1)'(c));
         div_ge1[c] = (div_q[c] != '0);
         div_ge2[c] = (div_q[c] > CNT_W'(1));
         at_last[c] = (cnt_q[c] == div_q[c] - CNT_W'(1));
      end
   end

   always_comb begin
      cfg_ready_d = ~wr_acc;
      cfg_err_d   = wr_acc & ({1'b0, cfg_ch} >= NChExt);
      for (int c = 0; c < int'(N_CH); c++) begin
         div_d[c]     = div_q[c];
         mode_d[c]    = mode_q[c];
         cnt_d[c]     = cnt_q[c];
         halted_d[c]  = halted_q[c];
         tick_d[c]    = tick_q[c];
         clk_out_d[c] = clk_out_q[c];

         if (wr_hit[c]) begin
            div_d[c]  = cfg_div;
            mode_d[c] = cfg_mode;
         end

         if (sync_all | wr_hit[c]) begin
            // Restart clears the phase and swallows any tick due this cycle.
            cnt_d[c]     = '0;
            halted_d[c]  = 1'b0;
            tick_d[c]    = 1'b0;
            clk_out_d[c] = 1'b0;
         end else if (!en[c]) begin
            // Disabled: phase and clk_out frozen, tick dropped.
            tick_d[c] = 1'b0;
         end else if (halted_q[c]) begin
            tick_d[c]    = 1'b0;
            clk_out_d[c] = 1'b0;
         end else begin
            tick_d[c]    = div_ge1[c] & at_last[c];
            clk_out_d[c] = div_ge2[c] & (cnt_q[c] >= (div_q[c] >> 1));
            if (!div_ge2[c] || at_last[c]) begin
               cnt_d[c] = '0;
            end else begin
               cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
            // One-shot channels park after their first tick.
            if (mode_q[c] && div_ge1[c] && at_last[c]) begin
               halted_d[c] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_0 or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < int'(N_CH); c++) begin
            div_q[c] <= DefDiv;
            cnt_q[c] <= '0;
         end
         mode_q      <= '0;
         halted_q    <= '0;
         tick_q      <= '0;
         clk_out_q   <= '0;
         cfg_ready_q <= 1'b1;
         cfg_err_q   <= 1'b0;
      end else begin
         for (int c = 0; c < int'(N_CH); c++) begin
            div_q[c] <= div_d[c];
            cnt_q[c] <= cnt_d[c];
         end
         mode_q      <= mode_d;
         halted_q    <= halted_d;
         tick_q      <= tick_d;
         clk_out_q   <= clk_out_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign tick      = tick_q;
   assign clk_out   = clk_out_q;
   assign cfg_ready = cfg_ready_q;
   assign cfg_err   = cfg_err_q;

endmodule
